// File: rtl/upstream_order_ingress_pkg.sv
// Shared types for the order ingress stage: payload struct, FSM states and
// transaction kinds used by the ingress top and its interface.
package upstream_pkg;

  localparam int CLIENT_W = 5;
  localparam int AMOUNT_W = 32;

  typedef struct packed {
    logic [CLIENT_W-1:0] client_id;
    logic [AMOUNT_W-1:0] amount;
  } order_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } ingress_state_t;

  typedef enum logic {
    ORD,
    MAX
  } txn_kind_t;

endpackage

// File: rtl/upstream_order_ingress_if.sv
// Client-side order/max streams plus the processor strobe/payload/done bus.
// The ingress block uses the slave view; its environment uses the master view.
interface upstream_order_ingress_if;
  import upstream_pkg::*;

  logic                ord_valid;
  logic                ord_ready;
  logic [CLIENT_W-1:0] ord_client_id;
  logic [AMOUNT_W-1:0] ord_amount;

  logic                max_valid;
  logic                max_ready;
  logic [CLIENT_W-1:0] max_client_id;
  logic [AMOUNT_W-1:0] max_amount;

  logic                new_order;
  logic                new_max;
  logic [CLIENT_W-1:0] out_order_client_id;
  logic [AMOUNT_W-1:0] out_order_amount;
  logic [CLIENT_W-1:0] out_max_client_id;
  logic [AMOUNT_W-1:0] out_max_amount;
  logic                proc_done;

  modport slave (
    input  ord_valid, ord_client_id, ord_amount,
    input  max_valid, max_client_id, max_amount,
    input  proc_done,
    output ord_ready, max_ready,
    output new_order, new_max,
    output out_order_client_id, out_order_amount,
    output out_max_client_id, out_max_amount
  );

  modport master (
    output ord_valid, ord_client_id, ord_amount,
    output max_valid, max_client_id, max_amount,
    output proc_done,
    input  ord_ready, max_ready,
    input  new_order, new_max,
    input  out_order_client_id, out_order_amount,
    input  out_max_client_id, out_max_amount
  );

endinterface

// File: rtl/upstream_order_ingress_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers. Push is ignored when full and
// pop when empty; full/empty come from registered pointers only.
module upstream_order_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  output T                           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign o_empty   = (r_wptr == r_rptr);
  assign o_count   = r_wptr - r_rptr;
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between valid pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/upstream_order_ingress.sv
// Ingress front-end: queues orders, holds one max update, and hands exactly one
// transaction at a time to the processor, abandoning it after TIMEOUT cycles.
module upstream_order_ingress
  import upstream_pkg::*;
#(
  parameter int ORD_DEPTH = 8,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         HRESET,
  upstream_order_ingress_if.slave      bus,
  output logic                         busy,
  output logic [$clog2(ORD_DEPTH):0]   fifo_count,
  output logic                         timeout_err,
  output logic [CNT_W-1:0]             drop_count
);

  localparam int            TW         = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  ingress_state_t   r_state;
  ingress_state_t   w_next_state;
  txn_kind_t        r_kind;
  order_t           r_max_entry;
  order_t           r_out_order;
  order_t           r_out_max;
  order_t           w_fifo_head;
  order_t           w_ord_in;
  logic             r_max_held;
  logic             r_timeout_err;
  logic [TW-1:0]    r_timer;
  logic [CNT_W-1:0] r_drop_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_max_push;
  logic             w_take_max;
  logic             w_timeout;

  assign w_ord_in      = {bus.ord_client_id, bus.ord_amount};
  assign bus.ord_ready = !w_full;
  assign bus.max_ready = !r_max_held;
  assign w_push        = bus.ord_valid && !w_full;
  assign w_max_push    = bus.max_valid && !r_max_held;
  // A held max update always wins arbitration over the order queue.
  assign w_take_max    = (r_state == IDLE) && r_max_held;
  assign w_pop         = (r_state == IDLE) && !r_max_held && !w_empty;
  assign w_timeout     = (r_state == WAIT) && !bus.proc_done && (r_timer == TIMER_LAST);

  upstream_order_fifo #(
    .DEPTH (ORD_DEPTH),
    .T     (order_t)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (HRESET),
    .i_push  (w_push),
    .i_data  (w_ord_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (HRESET) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_take_max || w_pop) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (bus.proc_done || w_timeout) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.new_order = 1'b0;
    bus.new_max   = 1'b0;
    if (r_state == ISSUE) begin
      bus.new_order = (r_kind == ORD);
      bus.new_max   = (r_kind == MAX);
    end
    busy = (r_state != IDLE);
  end

  assign bus.out_order_client_id = r_out_order.client_id;
  assign bus.out_order_amount    = r_out_order.amount;
  assign bus.out_max_client_id   = r_out_max.client_id;
  assign bus.out_max_amount      = r_out_max.amount;
  assign timeout_err             = r_timeout_err;
  assign drop_count              = r_drop_count;

  // Payload registers load only when leaving IDLE so they stay stable until done.
  always_ff @(posedge clk) begin
    if (HRESET) begin
      r_max_held    <= 1'b0;
      r_max_entry   <= '0;
      r_out_order   <= '0;
      r_out_max     <= '0;
      r_kind        <= ORD;
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_timeout_err <= w_timeout;
      if (w_max_push) begin
        r_max_held  <= 1'b1;
        r_max_entry <= {bus.max_client_id, bus.max_amount};
      end else if (w_take_max) begin
        r_max_held  <= 1'b0;
      end
      if (w_take_max) begin
        r_out_max <= r_max_entry;
        r_kind    <= MAX;
      end else if (w_pop) begin
        r_out_order <= w_fifo_head;
        r_kind      <= ORD;
      end
      if (r_state == ISSUE)                        r_timer <= '0;
      else if (r_state == WAIT && !bus.proc_done)  r_timer <= r_timer + 1'b1;
      if (w_timeout && (r_drop_count != '1))       r_drop_count <= r_drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_upstream_order_ingress.sv
// Scoreboard bench for upstream_order_ingress: accepted transfers are queued as
// expectations, a monitor pops them on each processor strobe and tracks timeouts.
module tb_upstream_order_ingress;
  import upstream_pkg::*;

  localparam int ORD_DEPTH = 8;
  localparam int TIMEOUT   = 64;
  localparam int CNT_W     = 16;

  logic                       clk = 1'b0;
  logic                       HRESET = 1'b1;
  logic                       busy;
  logic                       timeoutErr;
  logic [$clog2(ORD_DEPTH):0] fifoCount;
  logic [CNT_W-1:0]           dropCount;

  upstream_order_ingress_if bus();

  upstream_order_ingress #(
    .ORD_DEPTH (ORD_DEPTH),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .HRESET      (HRESET),
    .bus         (bus),
    .busy        (busy),
    .fifo_count  (fifoCount),
    .timeout_err (timeoutErr),
    .drop_count  (dropCount)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [36:0] ordQ[$];
  logic [36:0] maxQ[$];
  bit          pending = 0;
  bit          idleNext = 0;
  bit          autoDone = 0;
  bit          checkLatency = 0;
  bit          expectMaxFirst = 0;
  int          cnt = 0;
  int          acceptCyc = 0;
  int          modelDrop = 0;
  int          issuedOrd = 0;
  logic [36:0] heldPayload = '0;
  bit          heldIsMax = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=%0h required=nothing-expected", name, act);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Processor model: completes randomly a cycle or more after each strobe.
  initial begin
    bus.proc_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.proc_done = autoDone && pending && ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: pops expectations on strobes, checks payload hold, busy and timeouts.
  initial begin : monitor
    logic [36:0] act;
    forever begin
      @(negedge clk);
      if (HRESET) begin
        pending  = 0;
        idleNext = 0;
      end else begin
        if (idleNext) begin
          checkOutput("idle_after_done", busy, 0);
          idleNext = 0;
        end
        if (pending) begin
          cnt++;
          if (cnt <= TIMEOUT) begin
            if (timeoutErr) checkOutput("early_timeout", timeoutErr, 0);
            if (bus.proc_done) begin
              act = heldIsMax ? {bus.out_max_client_id, bus.out_max_amount}
                              : {bus.out_order_client_id, bus.out_order_amount};
              checkOutput("payload_stable", act, heldPayload);
              pending  = 0;
              idleNext = 1;
            end
          end else begin
            checkOutput("timeout_pulse", timeoutErr, 1);
            if (modelDrop < (2 ** CNT_W) - 1) modelDrop++;
            checkOutput("drop_count", dropCount, modelDrop);
            checkOutput("idle_after_timeout", busy, 0);
            pending = 0;
          end
        end else if (timeoutErr) begin
          checkOutput("spurious_timeout", timeoutErr, 0);
        end
        if (bus.new_order || bus.new_max) begin
          checkOutput("exclusive_strobes", bus.new_order & bus.new_max, 0);
          checkOutput("strobe_while_busy", pending, 0);
          if (expectMaxFirst) begin
            checkOutput("max_first", bus.new_max, 1);
            expectMaxFirst = 0;
          end
          if (bus.new_max) begin
            act = {bus.out_max_client_id, bus.out_max_amount};
            if (maxQ.size() == 0) reportFail("max_unexpected", act);
            else checkOutput("max_payload", act, maxQ.pop_front());
            heldIsMax = 1;
          end else begin
            act = {bus.out_order_client_id, bus.out_order_amount};
            if (ordQ.size() == 0) reportFail("order_unexpected", act);
            else checkOutput("order_payload", act, ordQ.pop_front());
            if (checkLatency) begin
              checkOutput("order_latency", cyc - acceptCyc, 2);
              checkLatency = 0;
            end
            issuedOrd++;
            heldIsMax = 0;
          end
          heldPayload = act;
          pending     = 1;
          cnt         = 0;
        end
      end
    end
  end

  // Drives one order and/or one max; call just after a rising edge.
  task automatic applyStimulus(input bit doOrd, input logic [4:0] oId, input logic [31:0] oAmt,
                               input bit doMax, input logic [4:0] mId, input logic [31:0] mAmt);
    bit ordLeft;
    bit maxLeft;
    int guard;
    ordLeft = doOrd;
    maxLeft = doMax;
    guard   = 0;
    bus.ord_valid     = doOrd;
    bus.ord_client_id = oId;
    bus.ord_amount    = oAmt;
    bus.max_valid     = doMax;
    bus.max_client_id = mId;
    bus.max_amount    = mAmt;
    while ((ordLeft || maxLeft) && guard < 200) begin
      @(negedge clk);
      if (ordLeft && bus.ord_ready) begin
        ordQ.push_back({oId, oAmt});
        acceptCyc = cyc;
        ordLeft   = 0;
      end
      if (maxLeft && bus.max_ready) begin
        maxQ.push_back({mId, mAmt});
        maxLeft = 0;
      end
      @(posedge clk);
      #1;
      bus.ord_valid = ordLeft;
      bus.max_valid = maxLeft;
      guard++;
    end
    if (ordLeft || maxLeft) reportFail("accept_timeout", guard);
    bus.ord_valid = 1'b0;
    bus.max_valid = 1'b0;
  endtask

  task automatic waitDrain(input int limit);
    int n;
    n = 0;
    while (!(ordQ.size() == 0 && maxQ.size() == 0 && !pending && !idleNext && busy == 1'b0)
           && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) reportFail("drain_timeout", n);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    HRESET        = 1'b1;
    bus.ord_valid = 1'b0;
    bus.max_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ordQ.delete();
    maxQ.delete();
    modelDrop      = 0;
    checkLatency   = 0;
    expectMaxFirst = 0;
    HRESET         = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_ord_ready"}, bus.ord_ready, 1);
    checkOutput({tag, "_max_ready"}, bus.max_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_fifo_count"}, fifoCount, 0);
    checkOutput({tag, "_new_order"}, bus.new_order, 0);
    checkOutput({tag, "_new_max"}, bus.new_max, 0);
    checkOutput({tag, "_timeout_err"}, timeoutErr, 0);
    checkOutput({tag, "_drop_count"}, dropCount, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    int baseIssued;
    bus.ord_valid     = 1'b0;
    bus.ord_client_id = '0;
    bus.ord_amount    = '0;
    bus.max_valid     = 1'b0;
    bus.max_client_id = '0;
    bus.max_amount    = '0;
    @(posedge clk);
    #1;
    doReset();
    checkResetState("reset");

    $display("[TB] single order into idle block");
    autoDone     = 1;
    checkLatency = 1;
    applyStimulus(1, 5'd3, 32'd100, 0, 5'd0, 32'd0);
    waitDrain(500);

    $display("[TB] max and order accepted together");
    expectMaxFirst = 1;
    applyStimulus(1, 5'd7, 32'd50, 1, 5'd7, 32'd500);
    waitDrain(500);

    $display("[TB] fill FIFO while processor stalls");
    autoDone = 0;
    for (int i = 1; i <= 9; i++)
      applyStimulus(1, 5'($urandom_range(0, 31)), 32'(i), 0, 5'd0, 32'd0);
    @(negedge clk);
    checkOutput("fill_count", fifoCount, 8);
    checkOutput("fill_ord_ready", bus.ord_ready, 0);
    @(posedge clk);
    #1;
    autoDone = 1;
    waitDrain(1000);
    checkOutput("fill_drop_count", dropCount, 0);

    $display("[TB] abandon a transaction on timeout");
    autoDone = 0;
    applyStimulus(1, 5'd1, 32'd11, 0, 5'd0, 32'd0);
    applyStimulus(1, 5'd2, 32'd22, 0, 5'd0, 32'd0);
    guard = 0;
    while (modelDrop == 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (modelDrop == 0) reportFail("timeout_never_seen", guard);
    @(posedge clk);
    #1;
    autoDone = 1;
    waitDrain(500);
    checkOutput("timeout_drop_total", dropCount, 1);

    $display("[TB] reset while waiting with work queued");
    autoDone = 0;
    for (int i = 1; i <= 5; i++)
      applyStimulus(1, 5'(i), 32'(200 + i), 0, 5'd0, 32'd0);
    applyStimulus(0, 5'd0, 32'd0, 1, 5'd9, 32'd999);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_count", fifoCount, 4);
    checkOutput("pre_reset_max_ready", bus.max_ready, 0);
    @(posedge clk);
    #1;
    doReset();
    checkResetState("mid_reset");
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] randomized wrap traffic");
    autoDone   = 1;
    baseIssued = issuedOrd;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 5'($urandom_range(0, 31)), $urandom,
                    (i % 5 == 4), 5'($urandom_range(0, 31)), $urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    waitDrain(2000);
    checkOutput("wrap_issued", issuedOrd - baseIssued, 20);
    checkOutput("wrap_drop_count", dropCount, 0);
    checkOutput("wrap_fifo_empty", fifoCount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=expired required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
